prng_sched_xoshiro128pp: RTL and testbench

//  Controller and arbiter for one xoshiro128++ core (prngXoshiro128pp), instantiated inside this block.

---
 rtl/prng_sched_xoshiro128pp_pkg.sv | 63 ++++++
 rtl/prng_sched_xoshiro128pp_rr_arbiter.sv | 49 ++++
 rtl/prng_sched_xoshiro128pp.sv | 219 +++++++++++++++++++++
 tb/tb_prng_sched_xoshiro128pp.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_sched_xoshiro128pp_pkg.sv
// ============================================================================
// Module   : prng_sched_xoshiro128pp_pkg
// Purpose  : Shared definitions for the xoshiro128++ scheduler. Contains the
//            FSM state encoding, the jump polynomial, the word width and the
//            xoshiro128++ step/output helper functions used by the
//            embedded core.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package prng_sched_xoshiro128pp_pkg;

    localparam int c_XOSHIRO_W = 32;

    // Jump polynomial as {word3, word2, word1, word0}. Bit k of this vector is
    // consumed in jump cycle k, so word0 bit0 is used first.
    localparam logic [127:0] c_JUMP_POLY = {32'h77f2db5b, 32'h6fa035c3,
                                            32'hf542d2d3, 32'h8764000b};

    localparam logic [2:0] c_ST_LOAD  = 3'd0;
    localparam logic [2:0] c_ST_PRIME = 3'd1;
    localparam logic [2:0] c_ST_RUN   = 3'd2;
    localparam logic [2:0] c_ST_JUMP  = 3'd3;
    localparam logic [2:0] c_ST_JLOAD = 3'd4;

    typedef enum logic [2:0] {
        ST_LOAD  = c_ST_LOAD,
        ST_PRIME = c_ST_PRIME,
        ST_RUN   = c_ST_RUN,
        ST_JUMP  = c_ST_JUMP,
        ST_JLOAD = c_ST_JLOAD
    } state_t;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned k);
        return (x << k) | (x >> (32 - k));
    endfunction

    // Output word for state {s3,s2,s1,s0}.
    function automatic logic [31:0] xo_result(input logic [127:0] s);
        return rotl32(s[31:0] + s[127:96], 7) + s[31:0];
    endfunction

    // One generator step for state {s3,s2,s1,s0}.
    function automatic logic [127:0] xo_next(input logic [127:0] s);
        logic [31:0] s0, s1, s2, s3, t;
        s0 = s[31:0];
        s1 = s[63:32];
        s2 = s[95:64];
        s3 = s[127:96];
        t  = s1 << 9;
        s2 = s2 ^ s0;
        s3 = s3 ^ s1;
        s1 = s1 ^ s2;
        s0 = s0 ^ s3;
        s2 = s2 ^ t;
        s3 = rotl32(s3, 11);
        return {s3, s2, s1, s0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/prng_sched_xoshiro128pp_rr_arbiter.sv
// ============================================================================
// Module   : prng_sched_xoshiro128pp_rr_arbiter
// Purpose  : Combinational round-robin arbiter. Grants the first valid
//            requester at or after the pointer, wrapping N_REQ-1 -> 0.
// Ports    : i_valid  [N_REQ]  request vector
//            i_ptr    [PW]     search start position (0..N_REQ-1)
//            o_grant  [N_REQ]  one-hot grant (zero when nothing is valid)
//            o_idx    [PW]     index of the granted requester
//            o_any             at least one requester is valid
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prng_sched_xoshiro128pp_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [PW-1:0]    o_idx,
    output logic             o_any
);

    logic [PW-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // Candidate position ptr+i folded back into 0..N_REQ-1.
            if (int'(i_ptr) + i >= N_REQ) begin
                w_pos = PW'(int'(i_ptr) + i - N_REQ);
            end else begin
                w_pos = PW'(int'(i_ptr) + i);
            end
            if (!o_any && i_valid[w_pos]) begin
                o_any          = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/prng_sched_xoshiro128pp.sv
// ============================================================================
// Module   : prng_sched_xoshiro128pp
// Purpose  : Controller and round-robin arbiter around one xoshiro128++
//            core. Seeds the core (default seed after reset, external
//            reseed, optional jump()) and shares its 32-bit output stream
//            among N_REQ requesters with valid/ready handshakes.
// Config   : define PRNG_SCHED_JUMP_EN to build the jump() sequencer
//            (JUMP/JLOAD states, accumulator, counter). Without it
//            i_jumpReq is ignored.
// Ports    : i_clk, i_rst      clock, synchronous active-high reset
//            i_seedValid       1-cycle pulse: load i_seed {s3,s2,s1,s0}
//            i_seed   [128]    external seed
//            i_jumpReq         1-cycle pulse: perform jump()
//            o_busy            not in RUN, no grants issued
//            i_reqValid [N]    per-requester request
//            o_reqReady [N]    one-hot grant, transfer = valid & ready
//            o_result   [32]   shared random word
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prng_sched_xoshiro128pp
    import prng_sched_xoshiro128pp_pkg::*;
#(
    parameter int           N_REQ = 4,
    parameter logic [127:0] SEED  = {32'd4, 32'd3, 32'd2, 32'd1}
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_seedValid,
    input  logic [127:0]           i_seed,
    input  logic                   i_jumpReq,
    output logic                   o_busy,
    input  logic [N_REQ-1:0]       i_reqValid,
    output logic [N_REQ-1:0]       o_reqReady,
    output logic [c_XOSHIRO_W-1:0] o_result
);

    localparam int c_PW = $clog2(N_REQ);

    // Controller state
    state_t          r_state_q, w_state_d;
    logic [c_PW-1:0] r_ptr_q,   w_ptr_d;
    logic [127:0]    r_seed_q,  w_seed_d;
    logic            r_busy_q,  w_busy_d;

    // Core state
    logic [127:0]            r_core_s_q, w_core_s_d;
    logic [c_XOSHIRO_W-1:0]  r_result_q, w_result_d;

    // Core control driven by the controller
    logic            w_core_load;
    logic [127:0]    w_core_seed;
    logic            w_core_cg;
    logic            w_grant_en;

`ifdef PRNG_SCHED_JUMP_EN
    logic [6:0]      r_cnt_q,   w_cnt_d;
    logic [127:0]    r_acc_q,   w_acc_d;
    logic            r_jpend_q, w_jpend_d;
`else
    logic            w_unused_jump;
    assign w_unused_jump = i_jumpReq;
`endif

    // Arbiter
    logic [N_REQ-1:0] w_arb_grant;
    logic [c_PW-1:0]  w_arb_idx;
    logic             w_arb_any;

    prng_sched_xoshiro128pp_rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (c_PW)
    ) u_arb (
        .i_valid (i_reqValid),
        .i_ptr   (r_ptr_q),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    // ------------------------------------------------------------------
    // Controller next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state_q;
        w_ptr_d     = r_ptr_q;
        w_seed_d    = r_seed_q;
        w_core_load = 1'b0;
        w_core_seed = r_seed_q;
        w_core_cg   = 1'b0;
        w_grant_en  = 1'b0;
`ifdef PRNG_SCHED_JUMP_EN
        w_cnt_d     = r_cnt_q;
        w_acc_d     = r_acc_q;
        w_jpend_d   = r_jpend_q;
`endif

        if (i_seedValid) begin
            // Reseed wins over everything but reset and aborts any jump.
            w_seed_d  = i_seed;
            w_state_d = ST_LOAD;
`ifdef PRNG_SCHED_JUMP_EN
            w_cnt_d   = '0;
            w_acc_d   = '0;
            w_jpend_d = 1'b0;
`endif
        end else begin
            case (r_state_q)
                ST_LOAD: begin
                    // Load dominates cg inside the core.
                    w_core_load = 1'b1;
                    w_core_cg   = 1'b1;
                    w_state_d   = ST_PRIME;
`ifdef PRNG_SCHED_JUMP_EN
                    if (i_jumpReq) w_jpend_d = 1'b1;
`endif
                end
                ST_PRIME: begin
                    // Produces result(seed) so the first word is ready in RUN.
                    w_core_cg = 1'b1;
                    w_state_d = ST_RUN;
`ifdef PRNG_SCHED_JUMP_EN
                    if (i_jumpReq) w_jpend_d = 1'b1;
`endif
                end
                ST_RUN: begin
`ifdef PRNG_SCHED_JUMP_EN
                    if (i_jumpReq || r_jpend_q) begin
                        w_state_d = ST_JUMP;
                        w_jpend_d = 1'b0;
                        w_cnt_d   = '0;
                    end else
`endif
                    begin
                        w_grant_en = 1'b1;
                        // The grant is only issued to a valid requester, so
                        // any valid request is a transfer this cycle.
                        if (w_arb_any) begin
                            w_core_cg = 1'b1;
                            w_ptr_d   = (w_arb_idx == c_PW'(N_REQ - 1)) ? '0
                                                                         : w_arb_idx + c_PW'(1);
                        end
                    end
                end
`ifdef PRNG_SCHED_JUMP_EN
                ST_JUMP: begin
                    w_core_cg = 1'b1;
                    if (c_JUMP_POLY[r_cnt_q]) w_acc_d = r_acc_q ^ r_core_s_q;
                    w_cnt_d = r_cnt_q + 7'd1;
                    if (r_cnt_q == 7'd127) w_state_d = ST_JLOAD;
                end
                ST_JLOAD: begin
                    w_core_load = 1'b1;
                    w_core_seed = r_acc_q;
                    w_core_cg   = 1'b1;
                    w_acc_d     = '0;
                    w_state_d   = ST_PRIME;
                end
`endif
                default: begin
                    w_state_d = ST_LOAD;
                end
            endcase
        end

        w_busy_d = (w_state_d != ST_RUN);
    end

    // ------------------------------------------------------------------
    // xoshiro128++ core: seed load has priority over a generate step
    // ------------------------------------------------------------------
    always_comb begin
        w_core_s_d = r_core_s_q;
        w_result_d = r_result_q;
        if (w_core_load) begin
            w_core_s_d = w_core_seed;
        end else if (w_core_cg) begin
            w_result_d = xo_result(r_core_s_q);
            w_core_s_d = xo_next(r_core_s_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q  <= ST_LOAD;
            r_ptr_q    <= '0;
            r_seed_q   <= SEED;
            r_busy_q   <= 1'b1;
            r_core_s_q <= '0;
            r_result_q <= '0;
`ifdef PRNG_SCHED_JUMP_EN
            r_cnt_q    <= '0;
            r_acc_q    <= '0;
            r_jpend_q  <= 1'b0;
`endif
        end else begin
            r_state_q  <= w_state_d;
            r_ptr_q    <= w_ptr_d;
            r_seed_q   <= w_seed_d;
            r_busy_q   <= w_busy_d;
            r_core_s_q <= w_core_s_d;
            r_result_q <= w_result_d;
`ifdef PRNG_SCHED_JUMP_EN
            r_cnt_q    <= w_cnt_d;
            r_acc_q    <= w_acc_d;
            r_jpend_q  <= w_jpend_d;
`endif
        end
    end

    assign o_busy     = r_busy_q;
    assign o_result   = r_result_q;
    // Reset also blanks grants in the cycle it is asserted.
    assign o_reqReady = (w_grant_en && !i_rst) ? w_arb_grant : '0;

endmodule

`default_nettype wire

// File: tb/tb_prng_sched_xoshiro128pp.sv
`default_nettype none

module tb_prng_sched_xoshiro128pp;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         seed_valid = 1'b0;
    logic [127:0] seed = '0;
    logic         jump_req = 1'b0;
    logic         busy;
    logic [3:0]   req_valid = 4'b0000;
    logic [3:0]   req_ready;
    logic [31:0]  result;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] SEED0 = {32'd4, 32'd3, 32'd2, 32'd1};

    // Reference state: m_out(m_s) is the word expected on o_result.
    logic [127:0] m_s;

    always #5 clk = ~clk;

    prng_sched_xoshiro128pp #(
        .N_REQ (4),
        .SEED  (SEED0)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_seedValid (seed_valid),
        .i_seed      (seed),
        .i_jumpReq   (jump_req),
        .o_busy      (busy),
        .i_reqValid  (req_valid),
        .o_reqReady  (req_ready),
        .o_result    (result)
    );

    // Reference xoshiro128++ written after the published C code.
    function automatic logic [31:0] m_rotl(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic logic [31:0] m_out(input logic [127:0] s);
        logic [31:0] a [4];
        for (int i = 0; i < 4; i++) a[i] = s[32*i +: 32];
        return m_rotl(a[0] + a[3], 7) + a[0];
    endfunction

    function automatic logic [127:0] m_next(input logic [127:0] s);
        logic [31:0] a [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) a[i] = s[32*i +: 32];
        t = a[1] << 9;
        a[2] ^= a[0];
        a[3] ^= a[1];
        a[1] ^= a[2];
        a[0] ^= a[3];
        a[2] ^= t;
        a[3] = m_rotl(a[3], 11);
        return {a[3], a[2], a[1], a[0]};
    endfunction

    function automatic logic [127:0] m_jump(input logic [127:0] s_in);
        logic [31:0]  jw [4];
        logic [127:0] s;
        logic [127:0] acc;
        jw[0] = 32'h8764000b;
        jw[1] = 32'hf542d2d3;
        jw[2] = 32'h6fa035c3;
        jw[3] = 32'h77f2db5b;
        s   = s_in;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 32; b++) begin
                if (jw[i][b]) acc ^= s;
                s = m_next(s);
            end
        end
        return acc;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reset and wait for RUN with no requester active.
    task automatic bring_up();
        req_valid = 4'b0000;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        m_s = SEED0;
    endtask

    task automatic test_reset();
        req_valid = 4'b0001;
        rst = 1'b1;
        cyc();
        cyc();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", busy); end
        n_cmp++;
        if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        rst = 1'b0;
        cyc();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_prime_busy: got %b want 1", busy); end
        cyc();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_run_busy: got %b want 0", busy); end
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL reset_first_grant: got %b want 0001", req_ready); end
        n_cmp++;
        if (result !== 32'h00000281) begin n_bad++; $display("FAIL reset_word0: got %h want 00000281", result); end
        cyc();
        n_cmp++;
        if (result !== 32'h00180387) begin n_bad++; $display("FAIL reset_word1: got %h want 00180387", result); end
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL reset_second_grant: got %b want 0001", req_ready); end
        req_valid = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        bring_up();
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            n_cmp++;
            if (req_ready !== exp_g) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_g); end
            n_cmp++;
            if (result !== m_out(m_s)) begin n_bad++; $display("FAIL rr_word[%0d]: got %h want %h", k, result, m_out(m_s)); end
            cyc();
            m_s = m_next(m_s);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_wrap_and_hold();
        logic [31:0] held;
        // Pointer is 1 here: req2 is granted, pointer moves to 3.
        req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL wrap_first: got %b want 0100", req_ready); end
        cyc();
        m_s = m_next(m_s);
        // Pointer 3, only req2 valid: search wraps 3 -> 0 -> 1 -> 2.
        n_cmp++;
        if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL wrap_grant: got %b want 0100", req_ready); end
        n_cmp++;
        if (result !== m_out(m_s)) begin n_bad++; $display("FAIL wrap_word: got %h want %h", result, m_out(m_s)); end
        cyc();
        m_s = m_next(m_s);
        req_valid = 4'b0000;
        held = m_out(m_s);
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if (result !== held || req_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL idle_hold[%0d]: got %h/%b want %h/0000", k, result, req_ready, held);
            end
            cyc();
        end
        // Pointer must still be 3, so req3 wins over req0.
        req_valid = 4'b1001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL ptr_after_wrap: got %b want 1000", req_ready); end
        n_cmp++;
        if (result !== held) begin n_bad++; $display("FAIL word_after_idle: got %h want %h", result, held); end
        cyc();
        m_s = m_next(m_s);
        req_valid = 4'b0000;
    endtask

    task automatic test_reseed();
        req_valid = 4'b0001;
        seed = SEED0;
        seed_valid = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reseed_no_grant: got %b want 0000", req_ready); end
        cyc();
        seed_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL reseed_busy0: got %b want 1", busy); end
        cyc();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL reseed_busy1: got %b want 1", busy); end
        cyc();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reseed_run: got %b want 0", busy); end
        n_cmp++;
        if (result !== 32'h00000281) begin n_bad++; $display("FAIL reseed_word0: got %h want 00000281", result); end
        cyc();
        n_cmp++;
        if (result !== 32'h00180387) begin n_bad++; $display("FAIL reseed_word1: got %h want 00180387", result); end
        req_valid = 4'b0000;
        m_s = m_next(SEED0);
`ifdef PRNG_SCHED_JUMP_EN
        jump_req = 1'b1;
        cyc();
        jump_req = 1'b0;
        repeat (39) cyc();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL midjump_busy: got %b want 1", busy); end
        seed_valid = 1'b1;
        cyc();
        seed_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy0: got %b want 1", busy); end
        cyc();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy1: got %b want 1", busy); end
        cyc();
        n_cmp++;
        if (busy !== 1'b0 || result !== 32'h00000281) begin
            n_bad++;
            $display("FAIL abort_run: got %b/%h want 0/00000281", busy, result);
        end
        repeat (3) cyc();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_stays_run: got %b want 0", busy); end
        m_s = SEED0;
`endif
    endtask

    task automatic test_jump();
`ifdef PRNG_SCHED_JUMP_EN
        int n_busy;
        // Core state sits one step past the pending word; jump applies there.
        jump_req = 1'b1;
        cyc();
        jump_req = 1'b0;
        n_busy = 0;
        while (busy === 1'b1 && n_busy < 300) begin
            n_busy++;
            cyc();
        end
        n_cmp++;
        if (n_busy != 130) begin n_bad++; $display("FAIL jump_busy_cycles: got %0d want 130", n_busy); end
        m_s = m_jump(m_next(m_s));
        n_cmp++;
        if (result !== m_out(m_s)) begin n_bad++; $display("FAIL jump_word0: got %h want %h", result, m_out(m_s)); end
        req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready === 4'b0000) begin n_bad++; $display("FAIL jump_grant: got %b want nonzero", req_ready); end
        cyc();
        m_s = m_next(m_s);
        req_valid = 4'b0000;
        n_cmp++;
        if (result !== m_out(m_s)) begin n_bad++; $display("FAIL jump_word1: got %h want %h", result, m_out(m_s)); end
`else
        // Without the jump build the request is ignored and grants proceed.
        req_valid = 4'b0001;
        jump_req = 1'b1;
        #1;
        n_cmp++;
        if (req_ready === 4'b0000) begin n_bad++; $display("FAIL nojump_grant: got %b want nonzero", req_ready); end
        cyc();
        m_s = m_next(m_s);
        jump_req = 1'b0;
        req_valid = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (busy !== 1'b0 || result !== m_out(m_s)) begin
                n_bad++;
                $display("FAIL nojump_idle[%0d]: got %b/%h want 0/%h", k, busy, result, m_out(m_s));
            end
            cyc();
        end
`endif
    endtask

    task automatic test_rst_mid();
        req_valid = 4'b0001;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_run_ready: got %b want 0000", req_ready); end
        cyc();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_run_busy: got %b want 1", busy); end
        rst = 1'b0;
        cyc();
        cyc();
        n_cmp++;
        if (busy !== 1'b0 || result !== 32'h00000281) begin
            n_bad++;
            $display("FAIL rst_run_replay0: got %b/%h want 0/00000281", busy, result);
        end
        cyc();
        n_cmp++;
        if (result !== 32'h00180387) begin n_bad++; $display("FAIL rst_run_replay1: got %h want 00180387", result); end
        req_valid = 4'b0000;
`ifdef PRNG_SCHED_JUMP_EN
        jump_req = 1'b1;
        cyc();
        jump_req = 1'b0;
        repeat (20) cyc();
        req_valid = 4'b0001;
        rst = 1'b1;
        cyc();
        n_cmp++;
        if (busy !== 1'b1 || req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_jump: got %b/%b want 1/0000", busy, req_ready);
        end
        rst = 1'b0;
        cyc();
        cyc();
        n_cmp++;
        if (busy !== 1'b0 || result !== 32'h00000281) begin
            n_bad++;
            $display("FAIL rst_jump_replay: got %b/%h want 0/00000281", busy, result);
        end
        req_valid = 4'b0000;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_wrap_and_hold();
        test_reseed();
        test_jump();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
